// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// branch_hazard_ctrl
// Resolves beq/bne in ID and inserts the stalls that forwarding cannot cover.
// Drives the PC redirect, the IF/ID flush and the branch statistics counters.
// Revision: 1.0
//------------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Branch_ID,
    input  logic             BranchNE,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic             rs_MUX,
    input  logic             rt_MUX,
    input  logic [31:0]      rs_RF,
    input  logic [31:0]      rt_RF,
    input  logic [31:0]      EX_MEM_ALUResult,
    input  logic [31:0]      PC_plus4_ID,
    input  logic [31:0]      imm_ID,
    output logic             Stall,
    output logic             PCSrc,
    output logic             Flush_IFID,
    output logic [31:0]      BranchTarget,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] TakenCount,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q, stall_cnt_q;

    logic             w_rs_idex, w_rt_idex, w_rs_exmem, w_rt_exmem;
    logic             w_haz2, w_haz1;
    logic             w_stall, w_eval, w_taken;
    logic [31:0]      w_op_a, w_op_b;

    // A producer only matches when it writes a real register ($0 is hardwired).
    assign w_rs_idex  = ID_EX_RegWrite  && (ID_EX_rd  != 5'd0) && (rs_ID == ID_EX_rd);
    assign w_rt_idex  = ID_EX_RegWrite  && (ID_EX_rd  != 5'd0) && (rt_ID == ID_EX_rd);
    assign w_rs_exmem = EX_MEM_RegWrite && (EX_MEM_rd != 5'd0) && (rs_ID == EX_MEM_rd);
    assign w_rt_exmem = EX_MEM_RegWrite && (EX_MEM_rd != 5'd0) && (rt_ID == EX_MEM_rd);

    // An EX/MEM ALU producer is covered by forwarding, so only its load case stalls.
    assign w_haz2 = (w_rs_idex || w_rt_idex) && ID_EX_MemRead;
    assign w_haz1 = ((w_rs_idex || w_rt_idex) && !ID_EX_MemRead) ||
                    ((w_rs_exmem || w_rt_exmem) && EX_MEM_MemRead);

    always_comb begin
        state_d = state_q;
        w_stall = 1'b0;
        w_eval  = 1'b0;
        case (state_q)
            RUN: begin
                if (Branch_ID) begin
                    if (w_haz2) begin
                        w_stall = 1'b1;
                        state_d = WAIT;
                    end else if (w_haz1) begin
                        w_stall = 1'b1;
                        state_d = RESOLVE;
                    end else begin
                        w_eval  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (Branch_ID) begin
                    w_stall = 1'b1;
                    state_d = RESOLVE;
                end else begin
                    state_d = RUN;
                end
            end
            RESOLVE: begin
                w_eval  = Branch_ID;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!Rst) begin
            w_stall = 1'b0;
            w_eval  = 1'b0;
        end
    end

    assign w_op_a  = rs_MUX ? EX_MEM_ALUResult : rs_RF;
    assign w_op_b  = rt_MUX ? EX_MEM_ALUResult : rt_RF;
    assign w_taken = w_eval && (BranchNE ? (w_op_a != w_op_b) : (w_op_a == w_op_b));

    assign Stall        = w_stall;
    assign PCSrc        = w_taken;
    assign Flush_IFID   = w_taken;
    assign BranchTarget = PC_plus4_ID + {imm_ID[29:0], 2'b00};
    assign BranchCount  = branch_cnt_q;
    assign TakenCount   = taken_cnt_q;
    assign StallCount   = stall_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= RUN;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_eval && (branch_cnt_q != C_CNT_MAX)) begin
                branch_cnt_q <= branch_cnt_q + C_CNT_ONE;
            end
            if (w_taken && (taken_cnt_q != C_CNT_MAX)) begin
                taken_cnt_q <= taken_cnt_q + C_CNT_ONE;
            end
            if (w_stall && (stall_cnt_q != C_CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + C_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_branch_hazard_ctrl
// Directed and randomized checks of branch_hazard_ctrl against a reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Branch_ID, BranchNE;
    logic [4:0]  rs_ID, rt_ID, ID_EX_rd, EX_MEM_rd;
    logic        ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_RegWrite, EX_MEM_MemRead;
    logic        rs_MUX, rt_MUX;
    logic [31:0] rs_RF, rt_RF, EX_MEM_ALUResult, PC_plus4_ID, imm_ID;

    logic        Stall, PCSrc, Flush_IFID, s_Stall, s_PCSrc, s_Flush_IFID;
    logic [31:0] BranchTarget, s_BranchTarget;
    logic [15:0] BranchCount, TakenCount, StallCount;
    logic [3:0]  s_BranchCount, s_TakenCount, s_StallCount;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase = number of cycles still to go before resolution.
    int          phase = 0;
    logic [31:0] bc16 = 0, tc16 = 0, sc16 = 0, bc4 = 0, tc4 = 0, sc4 = 0;

    always #5 Clk = ~Clk;

    branch_hazard_ctrl #(.CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Branch_ID(Branch_ID), .BranchNE(BranchNE),
        .rs_ID(rs_ID), .rt_ID(rt_ID),
        .ID_EX_rd(ID_EX_rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .rs_MUX(rs_MUX), .rt_MUX(rt_MUX), .rs_RF(rs_RF), .rt_RF(rt_RF),
        .EX_MEM_ALUResult(EX_MEM_ALUResult), .PC_plus4_ID(PC_plus4_ID), .imm_ID(imm_ID),
        .Stall(Stall), .PCSrc(PCSrc), .Flush_IFID(Flush_IFID), .BranchTarget(BranchTarget),
        .BranchCount(BranchCount), .TakenCount(TakenCount), .StallCount(StallCount)
    );

    branch_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .Clk(Clk), .Rst(Rst), .Branch_ID(Branch_ID), .BranchNE(BranchNE),
        .rs_ID(rs_ID), .rt_ID(rt_ID),
        .ID_EX_rd(ID_EX_rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .rs_MUX(rs_MUX), .rt_MUX(rt_MUX), .rs_RF(rs_RF), .rt_RF(rt_RF),
        .EX_MEM_ALUResult(EX_MEM_ALUResult), .PC_plus4_ID(PC_plus4_ID), .imm_ID(imm_ID),
        .Stall(s_Stall), .PCSrc(s_PCSrc), .Flush_IFID(s_Flush_IFID), .BranchTarget(s_BranchTarget),
        .BranchCount(s_BranchCount), .TakenCount(s_TakenCount), .StallCount(s_StallCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int reg_class(input logic [4:0] r);
        int c = 0;
        if (r != 0 && ID_EX_RegWrite && r == ID_EX_rd) c = ID_EX_MemRead ? 2 : 1;
        if (r != 0 && EX_MEM_RegWrite && r == EX_MEM_rd && EX_MEM_MemRead && c < 1) c = 1;
        return c;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic step();
        int          need, nphase, exp_state;
        logic        e_stall, e_eval, e_taken;
        logic [31:0] a, b;
        @(negedge Clk);
        need    = (reg_class(rs_ID) > reg_class(rt_ID)) ? reg_class(rs_ID) : reg_class(rt_ID);
        e_stall = 0;
        e_eval  = 0;
        nphase  = phase;
        if (!Rst) begin
            phase  = 0;
            nphase = 0;
            bc16 = 0; tc16 = 0; sc16 = 0; bc4 = 0; tc4 = 0; sc4 = 0;
        end else if (phase == 0) begin
            if (Branch_ID) begin
                if (need > 0) begin
                    e_stall = 1;
                    nphase  = need;
                end else begin
                    e_eval  = 1;
                end
            end
        end else if (!Branch_ID) begin
            nphase = 0;
        end else if (phase == 2) begin
            e_stall = 1;
            nphase  = 1;
        end else begin
            e_eval = 1;
            nphase = 0;
        end
        a = rs_MUX ? EX_MEM_ALUResult : rs_RF;
        b = rt_MUX ? EX_MEM_ALUResult : rt_RF;
        e_taken   = e_eval && (BranchNE ? (a != b) : (a == b));
        exp_state = (phase == 0) ? 0 : (phase == 2) ? 1 : 2;

        check("stall", 32'(Stall), 32'(e_stall));
        check("pcsrc", 32'(PCSrc), 32'(e_taken));
        check("flush", 32'(Flush_IFID), 32'(e_taken));
        check("target", BranchTarget, PC_plus4_ID + imm_ID * 4);
        check("state", 32'(dut.state_q), 32'(exp_state));
        check("bcnt", 32'(BranchCount), bc16);
        check("tcnt", 32'(TakenCount), tc16);
        check("scnt", 32'(StallCount), sc16);
        check("sat_stall", 32'(s_Stall), 32'(e_stall));
        check("sat_bcnt", 32'(s_BranchCount), bc4);
        check("sat_tcnt", 32'(s_TakenCount), tc4);
        check("sat_scnt", 32'(s_StallCount), sc4);

        @(posedge Clk);
        if (Rst) begin
            phase = nphase;
            if (e_eval)  begin bc16 = sat(bc16, 32'hFFFF); bc4 = sat(bc4, 32'hF); end
            if (e_taken) begin tc16 = sat(tc16, 32'hFFFF); tc4 = sat(tc4, 32'hF); end
            if (e_stall) begin sc16 = sat(sc16, 32'hFFFF); sc4 = sat(sc4, 32'hF); end
        end
        #1;
    endtask

    task automatic idle_inputs();
        Branch_ID = 0; BranchNE = 0; rs_ID = 0; rt_ID = 0;
        ID_EX_rd = 0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
        EX_MEM_rd = 0; EX_MEM_RegWrite = 0; EX_MEM_MemRead = 0;
        rs_MUX = 0; rt_MUX = 0; rs_RF = 0; rt_RF = 0;
        EX_MEM_ALUResult = 0; PC_plus4_ID = 0; imm_ID = 0;
    endtask

    task automatic do_reset();
        Rst = 0;
        step();
        Rst = 1;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        step();

        // ALU hazard: beq $1,$2 with producer of $1 in EX
        do_reset();
        Branch_ID = 1; rs_ID = 1; rt_ID = 2; ID_EX_rd = 1; ID_EX_RegWrite = 1;
        #1 check("alu_stall", 32'(Stall), 1);
        step();
        ID_EX_rd = 0; ID_EX_RegWrite = 0; rs_MUX = 1; EX_MEM_ALUResult = 5; rt_RF = 5;
        #1 check("alu_pcsrc", 32'(PCSrc), 1);
        step();
        Branch_ID = 0;
        check("alu_scnt", 32'(StallCount), 1);
        check("alu_tcnt", 32'(TakenCount), 1);

        // Load-use hazard: bne $3,$4 with a load of $4 in EX
        idle_inputs();
        do_reset();
        Branch_ID = 1; BranchNE = 1; rs_ID = 3; rt_ID = 4;
        ID_EX_rd = 4; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
        step();
        ID_EX_rd = 0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
        #1 check("lu_stall2", 32'(Stall), 1);
        step();
        rs_RF = 7; rt_RF = 7;
        #1 check("lu_pcsrc", 32'(PCSrc), 0);
        step();
        Branch_ID = 0;
        check("lu_scnt", 32'(StallCount), 2);
        check("lu_bcnt", 32'(BranchCount), 1);

        // No hazard, negative offset
        idle_inputs();
        Branch_ID = 1; rs_RF = 32'h10; rt_RF = 32'h10; PC_plus4_ID = 32'h100; imm_ID = 32'hFFFF_FFFF;
        #1;
        check("nh_target", BranchTarget, 32'hFC);
        check("nh_pcsrc", 32'(PCSrc), 1);
        check("nh_stall", 32'(Stall), 0);
        step();

        // $0 producer never matches
        idle_inputs();
        Branch_ID = 1; rs_ID = 0; rt_ID = 0; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
        #1 check("r0_stall", 32'(Stall), 0);
        step();

        // Mixed classes: rs on an EX/MEM load, rt on an ID/EX load
        idle_inputs();
        Branch_ID = 1; rs_ID = 5; rt_ID = 6;
        EX_MEM_rd = 5; EX_MEM_RegWrite = 1; EX_MEM_MemRead = 1;
        ID_EX_rd = 6; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
        step(); step(); step();

        // Reset asserted in WAIT, asynchronously
        idle_inputs();
        Branch_ID = 1; rs_ID = 2; ID_EX_rd = 2; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
        step();
        Rst = 0;
        #1;
        check("rw_stall", 32'(Stall), 0);
        check("rw_scnt", 32'(StallCount), 0);
        step();
        Rst = 1;
        step(); step(); step();

        // External flush in WAIT
        Branch_ID = 1;
        step();
        Branch_ID = 0;
        step(); step();

        // Saturation of the narrow instance
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            Branch_ID = 1;
            step();
        end
        check("sat_b15", 32'(s_BranchCount), 15);
        check("sat_t15", 32'(s_TakenCount), 15);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Rst              = ($urandom_range(0, 39) != 0);
            Branch_ID        = ($urandom_range(0, 9) < 7);
            BranchNE         = 1'($urandom_range(0, 1));
            rs_ID            = 5'($urandom_range(0, 3));
            rt_ID            = 5'($urandom_range(0, 3));
            ID_EX_rd         = 5'($urandom_range(0, 3));
            ID_EX_RegWrite   = 1'($urandom_range(0, 1));
            ID_EX_MemRead    = 1'($urandom_range(0, 1));
            EX_MEM_rd        = 5'($urandom_range(0, 3));
            EX_MEM_RegWrite  = 1'($urandom_range(0, 1));
            EX_MEM_MemRead   = 1'($urandom_range(0, 1));
            rs_MUX           = 1'($urandom_range(0, 1));
            rt_MUX           = 1'($urandom_range(0, 1));
            rs_RF            = $urandom_range(0, 2);
            rt_RF            = $urandom_range(0, 2);
            EX_MEM_ALUResult = $urandom_range(0, 2);
            PC_plus4_ID      = $urandom;
            imm_ID           = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
